mu0p_core: RTL
==============

MU0P_CORE -- requirements
Module: mu0p_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning data/accumulator/instruction width; legal only when DATA_W >= ADDR_W+4.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning memory address and PC width.
REQ-003 The block SHALL have port Clk  input  1  the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 The block SHALL have port Mem_Ack  input  1  memory transaction complete.
REQ-006 The block SHALL have port Din  input  DATA_W  memory read data, valid when Mem_Ack=1.
REQ-007 The block SHALL have port Mem_Req  output  1  memory transaction request.
REQ-008 The block SHALL have port Mem_Wr  output  1  1=write, 0=read; meaningful only while Mem_Req=1.
REQ-009 The block SHALL have port Address  output  ADDR_W  memory address.
REQ-010 The block SHALL have port Dout  output  DATA_W  write data, equal to Acc.
REQ-011 The block SHALL have ports PC  output  ADDR_W; Acc  output  DATA_W; F  output  4 (IR opcode field); N  output  1; Z  output  1; Halted  output  1.

Function
REQ-012 Instruction format SHALL be IR[DATA_W-1:DATA_W-4]=opcode and IR[ADDR_W-1:0]=operand address S; any bits between the two fields SHALL be ignored.
REQ-013 Opcodes SHALL be: 0 LDA (Acc<=mem[S]), 1 STA (mem[S]<=Acc), 2 ADD, 3 SUB (Acc<=Acc±mem[S]), 4 JMP, 5 JGE (taken when N=0), 6 JNE (taken when Z=0), 7 STP.
REQ-014 Undefined opcodes SHALL behave as NOP: single EXEC cycle, no state change, next state FETCH.
REQ-015 The FSM SHALL have exactly three states: FETCH, EXEC, HALT.
REQ-016 In FETCH, the block SHALL hold Mem_Req=1, Mem_Wr=0 and Address=PC; on an edge with Mem_Ack=1 it SHALL load IR<=Din, set PC<=PC+1 and go to EXEC.
REQ-017 In EXEC for LDA/ADD/SUB/STA, the block SHALL hold Mem_Req=1 and Address=S, with Mem_Wr=1 only for STA; on an edge with Mem_Ack=1 it SHALL update Acc (not for STA) and go to FETCH.
REQ-018 In EXEC for jumps, the block SHALL issue no request, load PC<=S when the jump is taken (PC unchanged otherwise), and go to FETCH in one cycle.
REQ-019 In EXEC for STP, the block SHALL go to HALT; HALT SHALL hold Mem_Req=0 and Halted=1 and be left only by Reset.
REQ-020 Handshake: while Mem_Ack=0, Mem_Req, Mem_Wr, Address and Dout SHALL be held stable with no state change; same-cycle Mem_Ack (zero wait) SHALL be legal.
REQ-021 Mem_Ack SHALL be ignored whenever Mem_Req=0.
REQ-022 Arithmetic SHALL be modulo 2^DATA_W with carry discarded; PC+1 SHALL wrap from all-ones to 0.
REQ-023 N SHALL equal Acc[DATA_W-1] and Z SHALL equal (Acc==0), both combinational from Acc.
REQ-024 With zero wait states, every instruction SHALL take 2 cycles; each wait cycle SHALL add exactly 1 cycle.

Reset
REQ-025 On Reset=0 the block SHALL immediately set PC=0, Acc=0, IR=0, state=FETCH, Mem_Req=0, Halted=0 and link register=0, abandoning any in-flight transaction.
REQ-026 Mem_Req SHALL be forced to 0 while Reset=0, and the first fetch from address 0 SHALL begin in the first cycle after release.

Configuration
REQ-027 With MU0P_LINK_EN defined, opcode 8 JSR SHALL set Link<=PC (the address after JSR) and PC<=S, and opcode 9 RET SHALL set PC<=Link; both SHALL be single-cycle EXEC with no memory request.
REQ-028 Without MU0P_LINK_EN, no link register SHALL exist and opcodes 8 and 9 SHALL be NOPs per REQ-014.

Structure
REQ-029 Package mu0p_pkg SHALL hold the opcode constants and the FSM state type.
REQ-030 The block SHALL contain one sub-module, mu0p_alu (parametrised DATA_W; pass, add and subtract operations).

Verification
REQ-031 With zero-wait memory, LDA 0x010 (mem=0x0005), ADD 0x011 (mem=0x0003), STA 0x012 -> write 0x0008 to 0x012, Acc=0x0008, and each instruction takes 2 cycles.
REQ-032 Hold Mem_Ack=0 for 3 cycles during fetch -> Address/Mem_Req stable throughout, PC unchanged until Ack, and the instruction takes 5 cycles.
REQ-033 With Acc=0x8000, JGE 0x020 -> not taken (PC = fetch address+1); then with Acc=0x0001, JNE 0x020 -> PC=0x020.
REQ-034 Place STP at 0xFFF after reset at PC=0xFFE -> Halted=1, Mem_Req=0, and it stays halted; a NOP at 0xFFF instead -> PC wraps to 0x000.
REQ-035 Assert Reset mid-STA with Mem_Ack low -> Mem_Req drops at once, no write occurs, and fetch at 0x000 starts after release.
REQ-036 With MU0P_LINK_EN, JSR 0x100 at 0x005 then RET -> fetch resumes at 0x006; without the macro, the same opcodes act as NOPs.

Source files
------------

// File: rtl/mu0p_pkg.sv
// Shared definitions for the MU0P accumulator core: opcodes, FSM states and ALU operations.
package mu0p_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_op_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_JSR = 4'h8;
    localparam logic [3:0] OP_RET = 4'h9;

    // Opcodes whose EXEC cycle needs a memory transaction.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0p_alu.sv
// Accumulator ALU: pass-through of the memory operand, or modulo add/subtract against Acc.
module mu0p_alu
    import mu0p_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = b_i;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/mu0p_core.sv
// MU0P accumulator CPU: FETCH/EXEC/HALT sequencer with a req/ack memory handshake.
// Define MU0P_LINK_EN to add a link register with JSR (opcode 8) and RET (opcode 9).
module mu0p_core
    import mu0p_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Din,
    output logic              Mem_Req,
    output logic              Mem_Wr,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Dout,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Acc,
    output logic [3:0]        F,
    output logic              N,
    output logic              Z,
    output logic              Halted
);

    // state    | meaning
    // ST_FETCH | read instruction at PC; on ack latch IR and bump PC
    // ST_EXEC  | execute IR; memory ops wait for ack, others take one cycle
    // ST_HALT  | STP executed; no requests until Reset

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              halted_q, halted_d;
`ifdef MU0P_LINK_EN
    logic [ADDR_W-1:0] link_q, link_d;
`endif

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              mem_op;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_y;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    assign mem_op  = is_mem_op(opcode);

    // IR bits between opcode and operand carry no meaning.
    generate
        if (DATA_W > ADDR_W + 4) begin : g_ir_gap
            logic unused_ir_gap;
            assign unused_ir_gap = ^ir_q[DATA_W-5:ADDR_W];
        end
    endgenerate

    always_comb begin
        alu_op = ALU_PASS;
        if (opcode == OP_ADD) begin
            alu_op = ALU_ADD;
        end else if (opcode == OP_SUB) begin
            alu_op = ALU_SUB;
        end
    end

    mu0p_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_i(alu_op),
        .a_i (acc_q),
        .b_i (Din),
        .y_o (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
`ifdef MU0P_LINK_EN
        link_d   = link_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (Mem_Ack) begin
                    ir_d    = Din;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        if (Mem_Ack) begin
                            acc_d   = alu_y;
                            state_d = ST_FETCH;
                        end
                    end
                    OP_STA: begin
                        if (Mem_Ack) begin
                            state_d = ST_FETCH;
                        end
                    end
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = ST_FETCH;
                    end
                    OP_JGE: begin
                        if (!acc_q[DATA_W-1]) begin
                            pc_d = operand;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_JNE: begin
                        if (acc_q != '0) begin
                            pc_d = operand;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_STP: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
`ifdef MU0P_LINK_EN
                    OP_JSR: begin
                        link_d  = pc_q;
                        pc_d    = operand;
                        state_d = ST_FETCH;
                    end
                    OP_RET: begin
                        pc_d    = link_q;
                        state_d = ST_FETCH;
                    end
`endif
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            acc_q    <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
`ifdef MU0P_LINK_EN
            link_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
`ifdef MU0P_LINK_EN
            link_q   <= link_d;
`endif
        end
    end

    // Reset gates the request so FETCH can present PC=0 the moment Reset releases.
    assign Mem_Req = Reset && ((state_q == ST_FETCH) || ((state_q == ST_EXEC) && mem_op));
    assign Mem_Wr  = Mem_Req && (state_q == ST_EXEC) && (opcode == OP_STA);
    assign Address = (state_q == ST_EXEC) ? operand : pc_q;
    assign Dout    = acc_q;

    assign PC     = pc_q;
    assign Acc    = acc_q;
    assign F      = opcode;
    assign N      = acc_q[DATA_W-1];
    assign Z      = (acc_q == '0);
    assign Halted = halted_q;

endmodule
